// File: rtl/fetch_pkg.sv
// Shared types and helpers for the LEGv8 fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned BR_OFF_W    = 26;
  localparam int unsigned CBR_OFF_W   = 19;

  // Signed word offset -> 64-bit byte offset.
  function automatic logic [63:0] sext_shift2(input logic [BR_OFF_W-1:0] offset);
    logic [63:0] ext;
    ext = {{(64 - BR_OFF_W){offset[BR_OFF_W-1]}}, offset};
    return ext << 2;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: BR > taken B/BL > taken CBZ/B.cond > sequential.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [63:0]          i_pc,
  input  logic                 i_br_taken,
  input  logic                 i_uncond_br,
  input  logic                 i_br_signal,
  input  logic [63:0]          i_reg_target,
  input  logic [BR_OFF_W-1:0]  i_br_addr,
  input  logic [CBR_OFF_W-1:0] i_cond_br_addr,
  output logic [63:0]          o_next_pc,
  output logic                 o_misaligned
);

  logic [63:0] w_br_off;
  logic [63:0] w_cbr_off;
  logic [63:0] w_seq_pc;
  logic [63:0] w_br_target;

  assign w_br_off  = sext_shift2(i_br_addr);
  assign w_cbr_off = sext_shift2({{(BR_OFF_W - CBR_OFF_W){i_cond_br_addr[CBR_OFF_W-1]}},
                                  i_cond_br_addr});
  assign w_seq_pc    = i_pc + 64'(INSTR_BYTES);
  assign w_br_target = {i_reg_target[63:2], 2'b00};

  always_comb begin
    o_next_pc = w_seq_pc;
    if (i_br_signal) begin
      o_next_pc = w_br_target;
    end else if (i_br_taken && i_uncond_br) begin
      o_next_pc = i_pc + w_br_off;
    end else if (i_br_taken) begin
      o_next_pc = i_pc + w_cbr_off;
    end
  end

  assign o_misaligned = i_br_signal && (i_reg_target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, fetches over a ready handshake, and presents
// one instruction at a time to decode until it is advanced.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [63:0]          imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          instruction,
  output logic [63:0]          pc,
  output logic                 instr_valid,
  output logic [63:0]          link_addr,
  input  logic                 advance,
  input  logic                 BrTaken,
  input  logic                 UnCondBr,
  input  logic                 BRsignal,
  input  logic [63:0]          reg_target,
  input  logic [BR_OFF_W-1:0]  BR_addr,
  input  logic [CBR_OFF_W-1:0] COND_BR_addr,
  output logic                 misalign_err,
  output logic [CNT_W-1:0]     fetch_count
);

  fetch_state_t     r_state;
  logic [63:0]      r_pc;
  logic [63:0]      r_link;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic             r_misalign;
  logic [CNT_W-1:0] r_count;

  logic [63:0]      w_next_pc;
  logic             w_misaligned;

  next_pc_calc u_next_pc_calc (
    .i_pc           (r_pc),
    .i_br_taken     (BrTaken),
    .i_uncond_br    (UnCondBr),
    .i_br_signal    (BRsignal),
    .i_reg_target   (reg_target),
    .i_br_addr      (BR_addr),
    .i_cond_br_addr (COND_BR_addr),
    .o_next_pc      (w_next_pc),
    .o_misaligned   (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_link     <= RESET_PC + 64'(INSTR_BYTES);
      r_instr    <= 32'h0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_count <= r_count + CNT_W'(1);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Branch controls are only trusted in the advance cycle.
          if (advance) begin
            r_pc    <= w_next_pc;
            r_link  <= w_next_pc + 64'(INSTR_BYTES);
            r_valid <= 1'b0;
            r_state <= FETCH;
            if (w_misaligned) begin
              r_misalign <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign imem_req     = (r_state == FETCH);
  assign imem_addr    = r_pc;
  assign instruction  = r_instr;
  assign pc           = r_pc;
  assign instr_valid  = r_valid;
  assign link_addr    = r_link;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with hand-computed expectations.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        instr_valid;
  logic [63:0] link_addr;
  logic        advance;
  logic        BrTaken;
  logic        UnCondBr;
  logic        BRsignal;
  logic [63:0] reg_target;
  logic [25:0] BR_addr;
  logic [18:0] COND_BR_addr;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC (64'h100),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .link_addr    (link_addr),
    .advance      (advance),
    .BrTaken      (BrTaken),
    .UnCondBr     (UnCondBr),
    .BRsignal     (BRsignal),
    .reg_target   (reg_target),
    .BR_addr      (BR_addr),
    .COND_BR_addr (COND_BR_addr),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    BrTaken      = 1'b0;
    UnCondBr     = 1'b0;
    BRsignal     = 1'b0;
    reg_target   = 64'h0;
    BR_addr      = 26'h0;
    COND_BR_addr = 19'h0;
  endtask

  // Two reset cycles, check reset values, then release and land in FETCH.
  task automatic do_reset();
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    advance    = 1'b0;
    clear_br();
    tick();
    tick();
    check_eq("rst_req",   64'(imem_req), 64'h0);
    check_eq("rst_addr",  imem_addr, 64'h100);
    check_eq("rst_pc",    pc, 64'h100);
    check_eq("rst_valid", 64'(instr_valid), 64'h0);
    check_eq("rst_link",  link_addr, 64'h104);
    check_eq("rst_instr", 64'(instruction), 64'h0);
    check_eq("rst_mis",   64'(misalign_err), 64'h0);
    check_eq("rst_cnt",   64'(fetch_count), 64'h0);
    reset_n = 1'b1;
    tick();
    check_eq("idle_to_fetch", 64'(imem_req), 64'h1);
  endtask

  task automatic do_fetch(input logic [63:0] at_pc, input logic [31:0] data,
                          input int waits, input logic [31:0] exp_cnt);
    logic [63:0] exp_link;
    exp_link = at_pc + 64'd4;
    for (int i = 0; i < waits; i++) begin
      check_eq("wait_req",  64'(imem_req), 64'h1);
      check_eq("wait_addr", imem_addr, at_pc);
      tick();
    end
    check_eq("fetch_req",  64'(imem_req), 64'h1);
    check_eq("fetch_addr", imem_addr, at_pc);
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check_eq("issue_valid", 64'(instr_valid), 64'h1);
    check_eq("issue_instr", 64'(instruction), 64'(data));
    check_eq("issue_pc",    pc, at_pc);
    check_eq("issue_link",  link_addr, exp_link);
    check_eq("issue_cnt",   64'(fetch_count), 64'(exp_cnt));
    check_eq("issue_req",   64'(imem_req), 64'h0);
    // Ready during ISSUE must not recapture.
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check_eq("issue_hold", 64'(instruction), 64'(data));
  endtask

  task automatic do_advance(input logic brs, input logic bt, input logic ub,
                            input logic [63:0] tgt, input logic [25:0] br,
                            input logic [18:0] cbr, input logic [63:0] exp_next);
    logic [63:0] exp_link;
    exp_link     = exp_next + 64'd4;
    BRsignal     = brs;
    BrTaken      = bt;
    UnCondBr     = ub;
    reg_target   = tgt;
    BR_addr      = br;
    COND_BR_addr = cbr;
    advance      = 1'b1;
    tick();
    advance = 1'b0;
    clear_br();
    check_eq("adv_req",   64'(imem_req), 64'h1);
    check_eq("adv_addr",  imem_addr, exp_next);
    check_eq("adv_link",  link_addr, exp_link);
    check_eq("adv_valid", 64'(instr_valid), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset then single-cycle fetch.
    do_reset();
    do_fetch(64'h100, 32'h9100_0421, 0, 32'd1);

    // Wait states, sequential advance, then an advance that lands in FETCH.
    do_reset();
    do_fetch(64'h100, 32'h8B02_0020, 3, 32'd1);
    do_advance(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0, 64'h104);
    advance  = 1'b1;
    BrTaken  = 1'b1;
    UnCondBr = 1'b1;
    BR_addr  = 26'h10;
    tick();
    advance = 1'b0;
    clear_br();
    check_eq("b2b_req",  64'(imem_req), 64'h1);
    check_eq("b2b_addr", imem_addr, 64'h104);
    do_fetch(64'h104, 32'hD503_201F, 0, 32'd2);

    // Unconditional backwards branch: -2 words.
    do_reset();
    do_fetch(64'h100, 32'h17FF_FFFE, 0, 32'd1);
    do_advance(1'b0, 1'b1, 1'b1, 64'h0, 26'h3FF_FFFE, 19'h0, 64'hF8);

    // Conditional forward branch, taken and not taken.
    do_reset();
    do_fetch(64'h100, 32'hB400_0080, 0, 32'd1);
    do_advance(1'b0, 1'b1, 1'b0, 64'h0, 26'h0, 19'h4, 64'h110);
    do_reset();
    do_fetch(64'h100, 32'hB400_0080, 0, 32'd1);
    do_advance(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h4, 64'h104);

    // BR priority, aligned then misaligned, sticky error.
    do_reset();
    do_fetch(64'h100, 32'hD61F_0000, 0, 32'd1);
    do_advance(1'b1, 1'b1, 1'b0, 64'h2000, 26'h0, 19'h0, 64'h2000);
    check_eq("br_ok_mis", 64'(misalign_err), 64'h0);
    do_fetch(64'h2000, 32'hD61F_0020, 0, 32'd2);
    do_advance(1'b1, 1'b1, 1'b1, 64'h2003, 26'h5, 19'h0, 64'h2000);
    check_eq("br_bad_mis", 64'(misalign_err), 64'h1);
    do_fetch(64'h2000, 32'h9100_0421, 0, 32'd3);
    check_eq("mis_sticky1", 64'(misalign_err), 64'h1);
    do_advance(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0, 64'h2004);
    check_eq("mis_sticky2", 64'(misalign_err), 64'h1);

    // Reset while in FETCH, then a late ready during IDLE.
    reset_n = 1'b0;
    tick();
    check_eq("midrst_req", 64'(imem_req), 64'h0);
    check_eq("midrst_pc",  pc, 64'h100);
    check_eq("midrst_mis", 64'(misalign_err), 64'h0);
    reset_n    = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check_eq("late_valid", 64'(instr_valid), 64'h0);
    check_eq("late_instr", 64'(instruction), 64'h0);
    check_eq("late_cnt",   64'(fetch_count), 64'h0);
    check_eq("late_req",   64'(imem_req), 64'h1);
    do_fetch(64'h100, 32'h9100_0421, 0, 32'd1);

    // PC wrap at the top of the address space.
    do_advance(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 26'h0, 19'h0,
               64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h8B1F_03E0, 0, 32'd2);
    do_advance(1'b0, 1'b0, 1'b0, 64'h0, 26'h0, 19'h0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
